// File: rtl/reorder_buffer.sv
// In-order commit buffer: allocates rename tags at dispatch, captures CDB results,
// retires one entry per cycle from the head and flushes on a mispredicted branch.
module reorder_buffer #(
    parameter int DEPTH = 16,
    parameter int TAG_W = 5
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             disp_valid,
    input  logic [1:0]       disp_type,
    input  logic [4:0]       disp_rd,
    output logic [TAG_W-1:0] next_tag,
    output logic             full,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_val,
    input  logic             cdb_mispredict,
    input  logic [31:0]      cdb_next_pc,
    input  logic [TAG_W-1:0] qry1_tag,
    input  logic [TAG_W-1:0] qry2_tag,
    output logic             qry1_ready,
    output logic             qry2_ready,
    output logic [31:0]      qry1_val,
    output logic [31:0]      qry2_val,
    output logic             write_rdy,
    output logic [4:0]       rd,
    output logic [31:0]      write_val,
    output logic [TAG_W-1:0] commit_tag,
    output logic             store_commit,
    output logic             clear,
    output logic [31:0]      redirect_pc
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [1:0] T_STORE  = 2'd1;
    localparam logic [1:0] T_BRANCH = 2'd2;

    logic [IW-1:0]    head, tail;
    logic [IW:0]      count;
    logic [DEPTH-1:0] e_busy, e_ready, e_misp;
    logic [1:0]       e_type [DEPTH];
    logic [4:0]       e_rd   [DEPTH];
    logic [31:0]      e_val  [DEPTH];
    logic [31:0]      e_pc   [DEPTH];

    logic [IW-1:0] cdb_idx, q1_idx, q2_idx;
    logic          cdb_hit, do_alloc, do_commit, do_flush;

    // Tags 1..DEPTH name entries; 0 and anything above DEPTH name no entry.
    function automatic logic tag_ok(input logic [TAG_W-1:0] t);
        return (t != '0) && (t <= TAG_W'(DEPTH));
    endfunction

    assign next_tag  = TAG_W'(tail) + TAG_W'(1);
    assign full      = (count == (IW+1)'(DEPTH));
    assign cdb_idx   = IW'(cdb_tag - TAG_W'(1));
    assign cdb_hit   = cdb_valid && tag_ok(cdb_tag) && e_busy[cdb_idx];
    assign do_alloc  = disp_valid && !full;
    assign do_commit = e_busy[head] && e_ready[head];
    assign do_flush  = do_commit && (e_type[head] == T_BRANCH) && e_misp[head];

    always_comb begin
        q1_idx     = IW'(qry1_tag - TAG_W'(1));
        qry1_ready = 1'b0;
        qry1_val   = '0;
        if (qry1_tag == '0) begin
            qry1_ready = 1'b1;
        end else if (cdb_valid && (cdb_tag == qry1_tag)) begin
            qry1_ready = 1'b1;
            qry1_val   = cdb_val;
        end else if (tag_ok(qry1_tag) && e_busy[q1_idx]) begin
            qry1_ready = e_ready[q1_idx];
            qry1_val   = e_val[q1_idx];
        end
    end

    always_comb begin
        q2_idx     = IW'(qry2_tag - TAG_W'(1));
        qry2_ready = 1'b0;
        qry2_val   = '0;
        if (qry2_tag == '0) begin
            qry2_ready = 1'b1;
        end else if (cdb_valid && (cdb_tag == qry2_tag)) begin
            qry2_ready = 1'b1;
            qry2_val   = cdb_val;
        end else if (tag_ok(qry2_tag) && e_busy[q2_idx]) begin
            qry2_ready = e_ready[q2_idx];
            qry2_val   = e_val[q2_idx];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            e_busy       <= '0;
            e_ready      <= '0;
            e_misp       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                e_type[i] <= '0;
                e_rd[i]   <= '0;
                e_val[i]  <= '0;
                e_pc[i]   <= '0;
            end
            write_rdy    <= 1'b0;
            store_commit <= 1'b0;
            clear        <= 1'b0;
            rd           <= '0;
            write_val    <= '0;
            commit_tag   <= '0;
            redirect_pc  <= '0;
        end else begin
            write_rdy    <= 1'b0;
            store_commit <= 1'b0;
            clear        <= 1'b0;
            // The cycle showing clear is dead: nothing is allocated, captured or retired.
            if (rdy_in && !clear) begin
                if (cdb_hit) begin
                    e_ready[cdb_idx] <= 1'b1;
                    e_val[cdb_idx]   <= cdb_val;
                    if (e_type[cdb_idx] == T_BRANCH) begin
                        e_misp[cdb_idx] <= cdb_mispredict;
                        e_pc[cdb_idx]   <= cdb_next_pc;
                    end
                end
                if (do_alloc) begin
                    e_busy[tail]  <= 1'b1;
                    e_ready[tail] <= 1'b0;
                    e_misp[tail]  <= 1'b0;
                    e_type[tail]  <= disp_type;
                    e_rd[tail]    <= disp_rd;
                    tail          <= tail + IW'(1);
                end
                if (do_commit) begin
                    e_busy[head] <= 1'b0;
                    head         <= head + IW'(1);
                    rd           <= e_rd[head];
                    write_val    <= e_val[head];
                    commit_tag   <= TAG_W'(head) + TAG_W'(1);
                    write_rdy    <= (e_type[head] != T_STORE) && (e_rd[head] != 5'd0);
                    store_commit <= (e_type[head] == T_STORE);
                end
                count <= count + (IW+1)'(do_alloc) - (IW+1)'(do_commit);
                if (do_flush) begin
                    clear       <= 1'b1;
                    redirect_pc <= e_pc[head];
                    e_busy      <= '0;
                    head        <= '0;
                    tail        <= '0;
                    count       <= '0;
                end
            end
        end
    end
endmodule
